// File: rtl/wb_regfile.sv
// Writeback-stage register file: selects the writeback value, commits it to a 32-entry GPR array,
// and serves two combinational read ports with same-cycle bypass. Also counts committed writes.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] MemoryData,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [ADDR_W-1:0] RegWriteAdd,
  input  logic [ADDR_W-1:0] ReadAdd1,
  input  logic [ADDR_W-1:0] ReadAdd2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData_Out,
  output logic [31:0]       WriteCount
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [1:NREG-1];
  logic [31:0]       count_q;
  logic [DATA_W-1:0] wdata;
  logic              commit;

  // Shared by WriteData_Out and the bypass so forwarding and decode always agree.
  assign wdata  = MemtoReg ? MemoryData : ALUResult;
  assign commit = RegWrite && (RegWriteAdd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else if (commit) begin
      regs_q[RegWriteAdd] <= wdata;
      count_q             <= count_q + 32'd1;
    end
  end

  always_comb begin
    ReadData1 = '0;
    if (ReadAdd1 != '0) begin
      if (RegWrite && (RegWriteAdd == ReadAdd1)) ReadData1 = wdata;
      else                                       ReadData1 = regs_q[ReadAdd1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (ReadAdd2 != '0) begin
      if (RegWrite && (RegWriteAdd == ReadAdd2)) ReadData2 = wdata;
      else                                       ReadData2 = regs_q[ReadAdd2];
    end
  end

  assign WriteData_Out = wdata;
  assign WriteCount    = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite, MemtoReg;
  logic [31:0] MemoryData, ALUResult;
  logic [4:0]  RegWriteAdd, ReadAdd1, ReadAdd2;
  logic [31:0] ReadData1, ReadData2, WriteData_Out, WriteCount;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [32];
  logic [31:0] cnt;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .MemoryData(MemoryData), .ALUResult(ALUResult), .RegWriteAdd(RegWriteAdd),
    .ReadAdd1(ReadAdd1), .ReadAdd2(ReadAdd2), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .WriteData_Out(WriteData_Out), .WriteCount(WriteCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_wd();
    return MemtoReg ? MemoryData : ALUResult;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWrite && RegWriteAdd == a) return exp_wd();
    return rst ? mem[a] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    cnt = 32'd0;
  endtask

  // Advance one rising edge, applying the architectural effect to the model.
  task automatic step();
    @(posedge clk);
    if (rst && RegWrite && RegWriteAdd != 5'd0) begin
      mem[RegWriteAdd] = exp_wd();
      cnt = cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic check_comb(input string tag);
    #1;
    check({tag, "_rd1"}, ReadData1, exp_rd(ReadAdd1));
    check({tag, "_rd2"}, ReadData2, exp_rd(ReadAdd2));
    check({tag, "_wd"},  WriteData_Out, exp_wd());
    check({tag, "_cnt"}, WriteCount, cnt);
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] md,
                       input logic [31:0] alu, input logic [4:0] wa,
                       input logic [4:0] r1, input logic [4:0] r2);
    RegWrite = we; MemtoReg = m2r; MemoryData = md; ALUResult = alu;
    RegWriteAdd = wa; ReadAdd1 = r1; ReadAdd2 = r2;
  endtask

  initial begin
    logic [31:0] c0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd31);
    model_reset();
    @(negedge clk);
    check_comb("reset");
    @(negedge clk);
    rst = 1'b1;

    // Basic write then read back.
    drive(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd7, 5'd1, 5'd2);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    check_comb("basic");
    check("basic_val", ReadData1, 32'hDEADBEEF);
    check("basic_cnt1", WriteCount, 32'd1);

    // Dual-port bypass from memory data.
    drive(1'b1, 1'b1, 32'hCAFEF00D, 32'h5, 5'd9, 5'd9, 5'd9);
    check_comb("byp");
    check("byp_val", ReadData2, 32'hCAFEF00D);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd7);
    check_comb("byp_after");
    check("byp_arr", ReadData1, 32'hCAFEF00D);

    // $0 is never written or bypassed, and not counted.
    c0 = cnt;
    drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    check_comb("r0");
    step();
    check_comb("r0_after");
    check("r0_cnt", WriteCount, c0);

    // MemtoReg select over two commits to $3.
    drive(1'b1, 1'b1, 32'h11, 32'h22, 5'd3, 5'd4, 5'd5);
    #1 check("m2r_mem", WriteData_Out, 32'h11);
    step();
    drive(1'b1, 1'b0, 32'h11, 32'h22, 5'd3, 5'd4, 5'd5);
    #1 check("m2r_alu", WriteData_Out, 32'h22);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
    check_comb("m2r_after");
    check("m2r_reg", ReadData1, 32'h22);
    check("m2r_cnt", WriteCount, c0 + 32'd2);

    // Randomized traffic.
    for (int it = 0; it < 600; it++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom, wa,
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
      check_comb("rand");
      step();
    end

    // Asynchronous reset mid-cycle after writing $5.
    drive(1'b1, 1'b0, 32'h0, 32'h1234, 5'd5, 5'd5, 5'd6);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);
    #1 check("pre_rst_5", ReadData1, 32'h1234);
    #1 rst = 1'b0;
    model_reset();
    #1 check("arst_rd1", ReadData1, 32'd0);
    check("arst_cnt", WriteCount, 32'd0);

    // Bypass stays live in reset, but nothing commits.
    drive(1'b1, 1'b0, 32'h0, 32'hABCD, 5'd9, 5'd9, 5'd8);
    check_comb("rst_byp");
    check("rst_byp_val", ReadData1, 32'hABCD);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd7);
    check_comb("rst_hold");
    rst = 1'b1;

    // First commit right after release.
    drive(1'b1, 1'b0, 32'h0, 32'h77, 5'd1, 5'd2, 5'd3);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd9);
    check_comb("post_rst");
    check("post_rst_cnt", WriteCount, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
